// File: rtl/grid_avs_pkg.sv
// Register map, bit positions and sizing helper shared by the grid Avalon-MM bridge.
package grid_avs_pkg;

    localparam logic [31:0] ADDR_GRID0  = 32'd0;
    localparam logic [31:0] ADDR_STATUS = 32'd7;
    localparam logic [31:0] ADDR_ROWS   = 32'd8;
    localparam logic [31:0] ADDR_CMD    = 32'd9;
    localparam logic [31:0] ADDR_CTRL   = 32'd10;

    localparam int ST_GO_LIVE   = 4;
    localparam int ST_GO_STICKY = 5;
    localparam int ST_ROW_PEND  = 6;
    localparam int ST_IRQ_EN    = 7;
    localparam int ST_SEQ_LSB   = 8;

    localparam int CMD_LEFT   = 0;
    localparam int CMD_RIGHT  = 1;
    localparam int CMD_DOWN   = 2;
    localparam int CMD_ROTATE = 3;

    localparam int CTRL_SNAP       = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_CLR_STICKY = 2;
    localparam int CTRL_CLR_ROWS   = 3;

    function automatic int grid_words(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/grid_avs_rise_det.sv
// Registered rising-edge detector: rise_o pulses for one cycle after the edge where sig_i is first seen high.
module grid_avs_rise_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    // Track the previous sample and register the edge pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/grid_avs_bridge.sv
// Avalon-MM responder exposing a tear-free grid snapshot, status, row count and
// a command path that turns CPU writes into single-cycle move/rotate pulses.
module grid_avs_bridge
    import grid_avs_pkg::*;
#(
    parameter int GRID_BITS = 200,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [GRID_BITS-1:0] grid_state,
    input  logic [3:0]           active_tetromino,
    input  logic                 row_cleared,
    input  logic                 game_over,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [DATA_W-1:0]    avs_writedata,
    output logic [DATA_W-1:0]    avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 irq,
    output logic                 cmd_left,
    output logic                 cmd_right,
    output logic                 cmd_down,
    output logic                 cmd_rotate
);

    localparam int GRID_WORDS = grid_words(GRID_BITS, DATA_W);
    localparam int PAD_W      = GRID_WORDS * DATA_W;

    logic [31:0]          addr_s;
    logic                 cmd_wr_s, ctrl_wr_s, clr_sticky_s, clr_rows_s;
    logic                 row_rise_s, go_rise_s;
    logic [PAD_W-1:0]     snap_pad_s;
    logic [DATA_W-1:0]    grid_word_s, status_s, ctrl_rb_s, rdata_s;
    logic                 unused_s;

    logic [GRID_BITS-1:0] snap_q, snap_d;
    logic [7:0]           seq_q, seq_d;
    logic [15:0]          rows_q, rows_d;
    logic                 row_pend_q, row_pend_d;
    logic                 go_sticky_q, go_sticky_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q;
    logic [3:0]           cmd_q, cmd_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rvalid_q;

    assign addr_s       = 32'(avs_address);
    assign cmd_wr_s     = avs_write & (addr_s == ADDR_CMD);
    assign ctrl_wr_s    = avs_write & (addr_s == ADDR_CTRL);
    assign clr_sticky_s = ctrl_wr_s & avs_writedata[CTRL_CLR_STICKY];
    assign clr_rows_s   = ctrl_wr_s & avs_writedata[CTRL_CLR_ROWS];
    assign snap_pad_s   = PAD_W'(snap_q);
    assign unused_s     = ^avs_writedata[DATA_W-1:4];

    grid_avs_rise_det u_row_rise (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .sig_i  (row_cleared),
        .rise_o (row_rise_s)
    );

    grid_avs_rise_det u_go_rise (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .sig_i  (game_over),
        .rise_o (go_rise_s)
    );

    // Read mux: built from current register values, so a same-cycle write is not visible.
    always_comb begin
        grid_word_s = '0;
        for (int k = 0; k < GRID_WORDS; k++) begin
            grid_word_s = grid_word_s |
                ((addr_s == ADDR_GRID0 + 32'(k)) ? snap_pad_s[k*DATA_W +: DATA_W] : '0);
        end
        status_s                   = '0;
        status_s[3:0]              = active_tetromino;
        status_s[ST_GO_LIVE]       = game_over;
        status_s[ST_GO_STICKY]     = go_sticky_q;
        status_s[ST_ROW_PEND]      = row_pend_q;
        status_s[ST_IRQ_EN]        = irq_en_q;
        status_s[ST_SEQ_LSB +: 8]  = seq_q;
        ctrl_rb_s                  = '0;
        ctrl_rb_s[CTRL_IRQ_EN]     = irq_en_q;
        case (addr_s)
            ADDR_STATUS: rdata_s = status_s;
            ADDR_ROWS:   rdata_s = DATA_W'(rows_q);
            ADDR_CMD:    rdata_s = '0;
            ADDR_CTRL:   rdata_s = ctrl_rb_s;
            default:     rdata_s = grid_word_s;
        endcase
    end

    // Next-state for snapshot, counters, sticky flags and command pulses.
    always_comb begin
        snap_d   = snap_q;
        seq_d    = seq_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr_s) begin
            irq_en_d = avs_writedata[CTRL_IRQ_EN];
            if (avs_writedata[CTRL_SNAP]) begin
                snap_d = grid_state;
                seq_d  = seq_q + 8'd1;
            end else begin
                snap_d = snap_q;
                seq_d  = seq_q;
            end
        end else begin
            irq_en_d = irq_en_q;
        end

        rows_d = rows_q;
        if (row_rise_s && clr_rows_s) begin
            rows_d = 16'd1;
        end else if (clr_rows_s) begin
            rows_d = 16'd0;
        end else if (row_rise_s && (rows_q != 16'hFFFF)) begin
            rows_d = rows_q + 16'd1;
        end else begin
            rows_d = rows_q;
        end

        row_pend_d  = row_rise_s | (row_pend_q & ~clr_sticky_s);
        go_sticky_d = go_rise_s | (go_sticky_q & ~clr_sticky_s);

        cmd_d = 4'b0000;
        if (cmd_wr_s) begin
            cmd_d[CMD_LEFT]   = avs_writedata[CMD_LEFT] & ~avs_writedata[CMD_RIGHT];
            cmd_d[CMD_RIGHT]  = avs_writedata[CMD_RIGHT] & ~avs_writedata[CMD_LEFT];
            cmd_d[CMD_DOWN]   = avs_writedata[CMD_DOWN];
            cmd_d[CMD_ROTATE] = avs_writedata[CMD_ROTATE];
        end else begin
            cmd_d = 4'b0000;
        end

        rdata_d = avs_read ? rdata_s : rdata_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q      <= '0;
            seq_q       <= 8'd0;
            rows_q      <= 16'd0;
            row_pend_q  <= 1'b0;
            go_sticky_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            cmd_q       <= 4'b0000;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            seq_q       <= seq_d;
            rows_q      <= rows_d;
            row_pend_q  <= row_pend_d;
            go_sticky_q <= go_sticky_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_en_q & (row_pend_q | go_sticky_q);
            cmd_q       <= cmd_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= avs_read;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;
    assign cmd_left          = cmd_q[CMD_LEFT];
    assign cmd_right         = cmd_q[CMD_RIGHT];
    assign cmd_down          = cmd_q[CMD_DOWN];
    assign cmd_rotate        = cmd_q[CMD_ROTATE];

endmodule

// File: tb/tb_grid_avs_bridge.sv
// Self-checking bench for grid_avs_bridge: vector table, directed corner sequences and
// randomized traffic checked cycle by cycle against a behavioural model of the register map.
module tb_grid_avs_bridge;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [199:0] grid_state;
    logic [3:0]   active_tetromino;
    logic         row_cleared, game_over;
    logic [4:0]   avs_address;
    logic         avs_read, avs_write;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid, irq;
    logic         cmd_left, cmd_right, cmd_down, cmd_rotate;

    always #5 clk = ~clk;

    grid_avs_bridge dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .grid_state        (grid_state),
        .active_tetromino  (active_tetromino),
        .row_cleared       (row_cleared),
        .game_over         (game_over),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq),
        .cmd_left          (cmd_left),
        .cmd_right         (cmd_right),
        .cmd_down          (cmd_down),
        .cmd_rotate        (cmd_rotate)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [199:0] m_snap;
    int           m_seq, m_rows;
    bit           m_pend, m_gos, m_irqen, m_rvalid;
    logic [31:0]  m_rdata;
    logic [3:0]   m_cmd;
    bit           m_row_prev, m_go_prev, m_row_rise, m_go_rise;

    typedef struct {
        bit           wr;
        logic [4:0]   addr;
        logic [31:0]  data;
        logic [199:0] grid;
        bit           chk;
        logic [31:0]  exp;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_snap = '0; m_seq = 0; m_rows = 0;
        m_pend = 1'b0; m_gos = 1'b0; m_irqen = 1'b0; m_rvalid = 1'b0;
        m_rdata = 32'd0; m_cmd = 4'd0;
        m_row_prev = 1'b0; m_go_prev = 1'b0; m_row_rise = 1'b0; m_go_rise = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        logic [199:0] sh;
        if (a < 7) begin
            sh = m_snap >> (32 * a);
            return sh[31:0];
        end
        if (a == 7) return {16'd0, 8'(m_seq), m_irqen, m_pend, m_gos, game_over, active_tetromino};
        if (a == 8) return 32'(m_rows);
        if (a == 10) return {30'd0, m_irqen, 1'b0};
        return 32'd0;
    endfunction

    // One clock: predict from the inputs seen at the edge, then compare all outputs.
    task automatic step();
        logic [31:0] wd;
        bit ctrl, cmdw, clr_st, clr_rows, exp_irq;
        wd       = avs_writedata;
        ctrl     = avs_write && (avs_address == 5'd10);
        cmdw     = avs_write && (avs_address == 5'd9);
        clr_st   = ctrl && wd[2];
        clr_rows = ctrl && wd[3];
        m_cmd    = cmdw ? {wd[3], wd[2], wd[1] & ~wd[0], wd[0] & ~wd[1]} : 4'd0;
        exp_irq  = m_irqen && (m_pend || m_gos);
        m_rvalid = avs_read;
        if (avs_read) m_rdata = m_read(int'(avs_address));
        if (m_row_rise) m_rows = clr_rows ? 1 : ((m_rows == 65535) ? 65535 : m_rows + 1);
        else if (clr_rows) m_rows = 0;
        m_pend = m_row_rise || (m_pend && !clr_st);
        m_gos  = m_go_rise || (m_gos && !clr_st);
        if (ctrl) begin
            m_irqen = wd[1];
            if (wd[0]) begin
                m_snap = grid_state;
                m_seq  = (m_seq + 1) % 256;
            end
        end
        m_row_rise = row_cleared && !m_row_prev;
        m_go_rise  = game_over && !m_go_prev;
        m_row_prev = row_cleared;
        m_go_prev  = game_over;
        @(posedge clk);
        #1;
        chk("rvalid", 32'(avs_readdatavalid), 32'(m_rvalid));
        chk("rdata", avs_readdata, m_rdata);
        chk("cmd", {28'd0, cmd_rotate, cmd_down, cmd_right, cmd_left}, {28'd0, m_cmd});
        chk("irq", 32'(irq), 32'(exp_irq));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        step();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        avs_address = a; avs_read = 1'b1;
        step();
        avs_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_row();
        row_cleared = 1'b1; idle(2);
        row_cleared = 1'b0; idle(2);
    endtask

    initial begin
        logic [199:0] g1;
        logic [223:0] rnd;
        g1 = 200'h1 | (200'h1 << 199);

        vecs[0]  = '{1'b0, 5'd0,  32'd0,  '0,  1'b1, 32'd0};
        vecs[1]  = '{1'b0, 5'd7,  32'd0,  '0,  1'b1, 32'd0};
        vecs[2]  = '{1'b0, 5'd8,  32'd0,  '0,  1'b1, 32'd0};
        vecs[3]  = '{1'b1, 5'd10, 32'h1,  g1,  1'b0, 32'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'd0,  '1,  1'b1, 32'h1};
        vecs[5]  = '{1'b0, 5'd6,  32'd0,  '1,  1'b1, 32'h80};
        vecs[6]  = '{1'b0, 5'd7,  32'd0,  '1,  1'b1, 32'h100};
        vecs[7]  = '{1'b0, 5'd9,  32'd0,  '1,  1'b1, 32'd0};
        vecs[8]  = '{1'b0, 5'd31, 32'd0,  '1,  1'b1, 32'd0};
        vecs[9]  = '{1'b1, 5'd10, 32'h2,  '1,  1'b0, 32'd0};
        vecs[10] = '{1'b0, 5'd10, 32'd0,  '1,  1'b1, 32'h2};
        vecs[11] = '{1'b0, 5'd7,  32'd0,  '1,  1'b1, 32'h180};

        reset_n = 1'b0; grid_state = '0; active_tetromino = 4'd0;
        row_cleared = 1'b0; game_over = 1'b0;
        avs_address = 5'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        model_reset();
        #12;
        chk("reset_outputs",
            {25'd0, avs_readdatavalid, irq, cmd_left, cmd_right, cmd_down, cmd_rotate, |avs_readdata},
            32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            grid_state = vecs[i].grid;
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else rd(vecs[i].addr);
            if (vecs[i].chk) chk($sformatf("vec%0d", i), avs_readdata, vecs[i].exp);
        end
        idle(1);

        wr(5'd9, 32'hC);
        chk("cmd_down_rot", {28'd0, cmd_rotate, cmd_down, cmd_right, cmd_left}, 32'hC);
        wr(5'd9, 32'h3);
        chk("cmd_lr_cancel", {28'd0, cmd_rotate, cmd_down, cmd_right, cmd_left}, 32'h0);
        wr(5'd9, 32'h1);
        chk("cmd_left", {28'd0, cmd_rotate, cmd_down, cmd_right, cmd_left}, 32'h1);
        idle(1);

        for (int i = 0; i < 3; i++) pulse_row();
        rd(5'd8);
        chk("rows3", avs_readdata, 32'd3);
        rd(5'd7);
        chk("row_pend", 32'(avs_readdata[6]), 32'd1);
        chk("irq_rows", 32'(irq), 32'd1);
        row_cleared = 1'b1; step();
        wr(5'd10, 32'h6);
        row_cleared = 1'b0; step();
        chk("irq_set_wins", 32'(irq), 32'd1);
        rd(5'd7);
        chk("pend_set_wins", 32'(avs_readdata[6]), 32'd1);
        rd(5'd8);
        chk("rows4", avs_readdata, 32'd4);

        game_over = 1'b1; idle(2);
        rd(5'd7);
        chk("status_go", avs_readdata, 32'h1F0);
        game_over = 1'b0; idle(1);

        force dut.rows_q = 16'hFFFE;
        #1;
        release dut.rows_q;
        m_rows = 65534;
        pulse_row();
        pulse_row();
        rd(5'd8);
        chk("rows_sat", avs_readdata, 32'hFFFF);
        row_cleared = 1'b1; step();
        wr(5'd10, 32'hA);
        row_cleared = 1'b0;
        rd(5'd8);
        chk("rows_clr_inc", avs_readdata, 32'd1);

        for (int i = 0; i < 600; i++) begin
            avs_read  = ($urandom_range(0, 1) == 1);
            avs_write = ($urandom_range(0, 3) == 0);
            avs_address = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 10));
            avs_writedata = $urandom;
            row_cleared = ($urandom_range(0, 2) == 0);
            game_over = ($urandom_range(0, 9) == 0);
            active_tetromino = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int w = 0; w < 7; w++) rnd[w*32 +: 32] = $urandom;
                grid_state = rnd[199:0];
            end
            step();
        end
        avs_read = 1'b0; avs_write = 1'b0; row_cleared = 1'b0; game_over = 1'b0;
        idle(2);

        avs_address = 5'd9; avs_writedata = 32'hC; avs_read = 1'b1; avs_write = 1'b1;
        step();
        chk("pre_rst_valid", 32'(avs_readdatavalid), 32'd1);
        chk("pre_rst_cmd", {28'd0, cmd_rotate, cmd_down, cmd_right, cmd_left}, 32'hC);
        avs_read = 1'b0; avs_write = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            {25'd0, avs_readdatavalid, irq, cmd_left, cmd_right, cmd_down, cmd_rotate, |avs_readdata},
            32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rd(5'd31);
        chk("post_rst_valid", 32'(avs_readdatavalid), 32'd1);
        chk("post_rst_data", avs_readdata, 32'd0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
